axis_bram_adapter_v1_0_seq: RTL and testbench
=============================================

// Module: axis_bram_adapter_v1_0_seq
// PURPOSE
//  Transfer sequencer directly upstream of axis_bram_adapter_v1_0_cntl. Accepts one command
//  (direction, start line, bound line), drives rw/addr_reload/start/bound into the controller,
//  gates both AXIS handshakes so only the commanded word count moves, and reports completion.
//  A write drains the final BRAM line before done; a read finishes on the controller's tlast beat.
// PARAMETERS
//  BRAM_ADDR_LENGTH    12  BRAM line index width
//  BRAM_WIDTH_IN_WORD  36  stream words per BRAM line
//  DRAIN_CYCLES        3   cycles waited after last write beat before done (>=2)
// PORTS
//  clk                 in   1    clock
//  rstn                in   1    reset, synchronous, active-low
//  cmd_valid           in   1    command offered
//  cmd_ready           out  1    command accepted when cmd_valid&cmd_ready
//  cmd_dir             in   1    1=write (stream->BRAM), 0=read (BRAM->stream)
//  cmd_start           in   A    first line index (A=BRAM_ADDR_LENGTH)
//  cmd_bound           in   A    last line index, inclusive
//  busy                out  1    high from accept until done pulse
//  done                out  1    one-cycle completion pulse
//  err                 out  1    one-cycle, coincident with done: bad command or tlast mismatch
//  s_axis_tvalid       in   1    upstream write data valid
//  s_axis_tready       out  1    upstream ready = (state==WR_RUN) && ctl_stream_in_accep
//  m_axis_tvalid       out  1    downstream valid = (state==RD_RUN) && ctl_stream_out_valid
//  m_axis_tready       in   1    downstream ready
//  m_axis_tlast        out  1    = m_axis_tvalid && ctl_stream_out_tlast
//  ctl_rw              out  1    to controller rw
//  ctl_addr_reload     out  1    to controller addr_reload
//  ctl_start_index     out  A    registered cmd_start
//  ctl_bound_index     out  A    registered cmd_bound
//  ctl_stream_in_valid out  1    = (state==WR_RUN) && s_axis_tvalid
//  ctl_stream_in_accep in   1    from controller
//  ctl_stream_out_valid in  1    from controller
//  ctl_stream_out_accep out 1    = (state==RD_RUN) && m_axis_tready
//  ctl_stream_out_tlast in  1    from controller
// BEHAVIOUR
//  Reset: state=IDLE; cmd_ready=1, busy=0, done=0, err=0, ctl_rw=1, ctl_addr_reload=0,
//   ctl indices=0, remaining=0; all gated stream outputs 0. Reset mid-transfer aborts, no done.
//  States: IDLE, LOAD0, LOAD1, WR_RUN, WR_DRAIN, RD_RUN, FIN.
//  IDLE: cmd_ready=1, ctl_rw=1 (controller parked, no BRAM reads). On accept: latch start/bound/dir;
//   if cmd_bound<cmd_start -> FIN with err pending, no stream/BRAM activity; else -> LOAD0.
//  remaining <= (bound-start+1)*BRAM_WIDTH_IN_WORD, width A+6 bits, no overflow.
//  LOAD0/LOAD1: ctl_addr_reload=1 both cycles; ctl_rw=dir from LOAD0 so controller rw_pre settles
//   and its word counter clears before run. Then -> WR_RUN (dir=1) or RD_RUN (dir=0).
//  WR_RUN: each s_axis_tvalid&s_axis_tready beat decrements remaining; beat taking it 1->0 -> WR_DRAIN
//   (that beat is the last transferred; s_axis_tready low from next cycle).
//  WR_DRAIN: ctl_rw stays 1, counts DRAIN_CYCLES cycles -> FIN (final line write committed).
//  RD_RUN: each m_axis_tvalid&m_axis_tready beat decrements remaining; beat with ctl_stream_out_tlast
//   -> FIN. If remaining hits 0 without tlast, or tlast with remaining!=1 -> FIN with err.
//  FIN: done=1 (err=1 if pending), busy=0 next, ctl_rw<=1, -> IDLE; cmd_ready low in FIN.
//  cmd_ready=0 in all non-IDLE states; commands cannot queue. busy=1 LOAD0..FIN exclusive of IDLE.
//  Stream stalls (tvalid/tready low) freeze counters; no timeout.
// TESTING
//  1 write start=4 bound=4: 36 beats back-to-back -> s_axis_tready low after beat 36, done 3 cycles later,
//    err=0; ctl_addr_reload high exactly 2 cycles with ctl_start_index=4.
//  2 write start=0 bound=2 with random tvalid gaps -> exactly 108 beats accepted, 109th offered beat
//    sees tready=0, single done pulse.
//  3 read start=10 bound=11, m_axis_tready always 1 -> 72 beats, m_axis_tlast on beat 72 only,
//    done the cycle after, err=0; ctl_rw=0 during RD_RUN, back to 1 after FIN.
//  4 read with m_axis_tready toggling 1/0 -> beat count still 72, tlast on 72nd accepted beat.
//  5 cmd start=5 bound=3 -> accepted, done=err=1 within 2 cycles, no ctl_addr_reload, no beats.
//  6 rstn low mid write (beat 20) -> all outputs at reset values next cycle, no done; new cmd accepted.

Source files
------------

// File: rtl/axis_bram_adapter_v1_0_seq_if.sv
// Bundle of command, status, gated AXIS and controller-side signals around the transfer sequencer.
// The slave modport is the sequencer's view; master is the surrounding logic's view.
interface axis_bram_adapter_v1_0_seq_if #(
    parameter int ADDR_W = 12
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic [ADDR_W-1:0] cmd_start;
    logic [ADDR_W-1:0] cmd_bound;
    logic              busy;
    logic              done;
    logic              err;
    logic [2:0]        state_dbg;

    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;

    logic              ctl_rw;
    logic              ctl_addr_reload;
    logic [ADDR_W-1:0] ctl_start_index;
    logic [ADDR_W-1:0] ctl_bound_index;
    logic              ctl_stream_in_valid;
    logic              ctl_stream_in_accep;
    logic              ctl_stream_out_valid;
    logic              ctl_stream_out_accep;
    logic              ctl_stream_out_tlast;

    modport slave (
        input  cmd_valid, cmd_dir, cmd_start, cmd_bound,
        output cmd_ready, busy, done, err, state_dbg,
        input  s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tlast,
        output ctl_rw, ctl_addr_reload, ctl_start_index, ctl_bound_index,
        output ctl_stream_in_valid, ctl_stream_out_accep,
        input  ctl_stream_in_accep, ctl_stream_out_valid, ctl_stream_out_tlast
    );

    modport master (
        output cmd_valid, cmd_dir, cmd_start, cmd_bound,
        input  cmd_ready, busy, done, err, state_dbg,
        output s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tlast,
        input  ctl_rw, ctl_addr_reload, ctl_start_index, ctl_bound_index,
        input  ctl_stream_in_valid, ctl_stream_out_accep,
        output ctl_stream_in_accep, ctl_stream_out_valid, ctl_stream_out_tlast
    );
endinterface

// File: rtl/axis_bram_adapter_v1_0_seq.sv
// Transfer sequencer in front of the AXIS/BRAM controller: takes one line-range command, gates
// the stream handshakes so exactly the commanded word count moves, and pulses done/err at the end.
module axis_bram_adapter_v1_0_seq #(
    parameter int BRAM_ADDR_LENGTH   = 12,
    parameter int BRAM_WIDTH_IN_WORD = 36,
    parameter int DRAIN_CYCLES       = 3
) (
    input logic clk,
    input logic rstn,
    axis_bram_adapter_v1_0_seq_if.slave bus
);
    localparam int A       = BRAM_ADDR_LENGTH;
    localparam int REM_W   = A + 6;
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD0    = 3'd1,
        LOAD1    = 3'd2,
        WR_RUN   = 3'd3,
        WR_DRAIN = 3'd4,
        RD_RUN   = 3'd5,
        FIN      = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic               dir_q;
    logic               err_pend_q, err_pend_d;
    logic [A-1:0]       start_q, bound_q;
    logic [REM_W-1:0]   remaining_q, remaining_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [REM_W-1:0]   span_words;
    logic               cmd_fire, bad_cmd;
    logic               in_gate, out_gate;
    logic               wr_beat, rd_beat;

    // Every handshake here transfers on the cycle where valid && ready are both high at the
    // clock edge; valid never waits on ready, and ready is only ever gated, never forced high.
    assign cmd_fire = bus.cmd_valid && (state_q == IDLE);
    assign bad_cmd  = bus.cmd_bound < bus.cmd_start;
    assign in_gate  = (state_q == WR_RUN);
    assign out_gate = (state_q == RD_RUN);
    assign wr_beat  = in_gate && bus.s_axis_tvalid && bus.ctl_stream_in_accep;
    assign rd_beat  = out_gate && bus.ctl_stream_out_valid && bus.m_axis_tready;

    // Inclusive line span times words per line; the +6 bits cover the 36x factor with headroom.
    assign span_words = (REM_W'(bus.cmd_bound) - REM_W'(bus.cmd_start) + REM_W'(1))
                        * REM_W'(BRAM_WIDTH_IN_WORD);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            dir_q       <= 1'b1;
            err_pend_q  <= 1'b0;
            start_q     <= '0;
            bound_q     <= '0;
            remaining_q <= '0;
            drain_q     <= '0;
        end else begin
            state_q     <= state_d;
            err_pend_q  <= err_pend_d;
            remaining_q <= remaining_d;
            drain_q     <= drain_d;
            if (cmd_fire) begin
                dir_q   <= bus.cmd_dir;
                start_q <= bus.cmd_start;
                bound_q <= bus.cmd_bound;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        err_pend_d  = err_pend_q;
        remaining_d = remaining_q;
        drain_d     = drain_q;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    drain_d = '0;
                    if (bad_cmd) begin
                        remaining_d = '0;
                        err_pend_d  = 1'b1;
                        state_d     = FIN;
                    end else begin
                        remaining_d = span_words;
                        err_pend_d  = 1'b0;
                        state_d     = LOAD0;
                    end
                end
            end
            LOAD0: state_d = LOAD1;
            LOAD1: state_d = dir_q ? WR_RUN : RD_RUN;
            WR_RUN: begin
                if (wr_beat) begin
                    remaining_d = remaining_q - REM_W'(1);
                    if (remaining_q == REM_W'(1)) state_d = WR_DRAIN;
                end
            end
            WR_DRAIN: begin
                // Hold rw high long enough for the controller to commit its last partial line.
                if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) state_d = FIN;
                else drain_d = drain_q + DRAIN_W'(1);
            end
            RD_RUN: begin
                if (rd_beat) begin
                    remaining_d = remaining_q - REM_W'(1);
                    if (bus.ctl_stream_out_tlast) begin
                        state_d    = FIN;
                        err_pend_d = (remaining_q != REM_W'(1));
                    end else if (remaining_q == REM_W'(1)) begin
                        state_d    = FIN;
                        err_pend_d = 1'b1;
                    end
                end
            end
            FIN: begin
                state_d    = IDLE;
                err_pend_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == FIN);
    assign bus.err       = (state_q == FIN) && err_pend_q;
    assign bus.state_dbg = state_q;

    // rw follows the command only while loading/running; otherwise the controller stays parked.
    always_comb begin
        bus.ctl_rw = 1'b1;
        if (state_q == LOAD0 || state_q == LOAD1 || state_q == WR_RUN || state_q == RD_RUN)
            bus.ctl_rw = dir_q;
    end

    assign bus.ctl_addr_reload      = (state_q == LOAD0) || (state_q == LOAD1);
    assign bus.ctl_start_index      = start_q;
    assign bus.ctl_bound_index      = bound_q;
    assign bus.ctl_stream_in_valid  = in_gate && bus.s_axis_tvalid;
    assign bus.s_axis_tready        = in_gate && bus.ctl_stream_in_accep;
    assign bus.m_axis_tvalid        = out_gate && bus.ctl_stream_out_valid;
    assign bus.ctl_stream_out_accep = out_gate && bus.m_axis_tready;
    assign bus.m_axis_tlast         = out_gate && bus.ctl_stream_out_valid && bus.ctl_stream_out_tlast;
endmodule

// File: tb/tb_axis_bram_adapter_v1_0_seq.sv
// Directed bench for the transfer sequencer; a small read-side controller stand-in raises tlast
// after the programmed number of accepted words.
module tb_axis_bram_adapter_v1_0_seq;
    localparam int A = 12;

    logic clk;
    logic rstn;
    int   n_run;
    int   n_fail;
    int   model_total;
    logic [15:0] model_cnt;

    axis_bram_adapter_v1_0_seq_if #(.ADDR_W(A)) bus ();

    axis_bram_adapter_v1_0_seq #(
        .BRAM_ADDR_LENGTH(A),
        .BRAM_WIDTH_IN_WORD(36),
        .DRAIN_CYCLES(3)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // read-side controller stand-in: data available whenever reading and not reloading
    always @(posedge clk) begin
        if (!rstn || bus.ctl_addr_reload) model_cnt <= '0;
        else if (bus.ctl_stream_out_valid && bus.ctl_stream_out_accep) model_cnt <= model_cnt + 16'd1;
    end
    assign bus.ctl_stream_out_valid = !bus.ctl_rw && !bus.ctl_addr_reload;
    assign bus.ctl_stream_out_tlast = (int'(model_cnt) == model_total - 1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic issue(input logic dir, input logic [A-1:0] s, input logic [A-1:0] b, input string tag);
        @(posedge clk); #2;
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = dir;
        bus.cmd_start = s;
        bus.cmd_bound = b;
        #1;
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    endtask

    task automatic run_write(input string tag, input int exp_beats, input bit gaps, input int exp_start);
        int beats = 0, reloads = 0, idx_bad = 0, early_done = 0, cyc = 0, n = 1;
        while (beats < exp_beats && cyc < 3000) begin
            @(posedge clk); #2;
            bus.cmd_valid           = 1'b0;
            bus.s_axis_tvalid       = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.ctl_stream_in_accep = gaps ? 1'($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (bus.ctl_addr_reload) begin
                reloads++;
                if (int'(bus.ctl_start_index) != exp_start) idx_bad++;
            end
            if (bus.done) early_done++;
            if (bus.s_axis_tvalid && bus.s_axis_tready) beats++;
            cyc++;
        end
        check({tag, "_beats"}, beats, exp_beats);
        check({tag, "_reload_cycles"}, reloads, 2);
        check({tag, "_reload_index_bad"}, idx_bad, 0);
        check({tag, "_early_done"}, early_done, 0);
        // offer one beat beyond the commanded count
        @(posedge clk); #2;
        bus.s_axis_tvalid       = 1'b1;
        bus.ctl_stream_in_accep = 1'b1;
        #1;
        check({tag, "_extra_tready"}, bus.s_axis_tready, 0);
        check({tag, "_drain_state"}, bus.state_dbg, 4);
        check({tag, "_drain_rw"}, bus.ctl_rw, 1);
        while (!bus.done && n < 20) begin
            @(posedge clk); #3;
            n++;
        end
        check({tag, "_done_cycle"}, n, 4);
        check({tag, "_err"}, bus.err, 0);
        @(posedge clk); #2;
        bus.s_axis_tvalid = 1'b0;
        #1;
        check({tag, "_done_single"}, bus.done, 0);
        check({tag, "_busy_after"}, bus.busy, 0);
        check({tag, "_cmd_ready_after"}, bus.cmd_ready, 1);
    endtask

    task automatic run_read(input string tag, input int exp_beats, input bit toggle);
        int beats = 0, tlasts = 0, last_at = 0, rw_bad = 0, cyc = 0;
        bit got_last = 1'b0;
        while (!got_last && cyc < 3000) begin
            @(posedge clk); #2;
            bus.cmd_valid     = 1'b0;
            bus.m_axis_tready = toggle ? 1'(cyc % 2 == 0) : 1'b1;
            #1;
            if (bus.state_dbg == 3'd5 && bus.ctl_rw !== 1'b0) rw_bad++;
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                beats++;
                if (bus.m_axis_tlast) begin
                    tlasts++;
                    last_at  = beats;
                    got_last = 1'b1;
                end
            end
            cyc++;
        end
        @(posedge clk); #2;
        bus.m_axis_tready = 1'b0;
        #1;
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_fin_rw"}, bus.ctl_rw, 1);
        @(posedge clk); #3;
        check({tag, "_done_single"}, bus.done, 0);
        check({tag, "_busy_after"}, bus.busy, 0);
        check({tag, "_beats"}, beats, exp_beats);
        check({tag, "_tlast_count"}, tlasts, 1);
        check({tag, "_tlast_at"}, last_at, exp_beats);
        check({tag, "_run_rw"}, rw_bad, 0);
    endtask

    initial begin
        int beats, dones, errs, reloads, done_at;
        n_run                   = 0;
        n_fail                  = 0;
        model_total             = 72;
        rstn                    = 1'b0;
        bus.cmd_valid           = 1'b0;
        bus.cmd_dir             = 1'b0;
        bus.cmd_start           = '0;
        bus.cmd_bound           = '0;
        bus.s_axis_tvalid       = 1'b0;
        bus.m_axis_tready       = 1'b0;
        bus.ctl_stream_in_accep = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        #3;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_rw", bus.ctl_rw, 1);
        check("rst_reload", bus.ctl_addr_reload, 0);
        check("rst_start_idx", bus.ctl_start_index, 0);
        check("rst_bound_idx", bus.ctl_bound_index, 0);
        check("rst_s_tready", bus.s_axis_tready, 0);
        check("rst_m_tvalid", bus.m_axis_tvalid, 0);
        check("rst_state", bus.state_dbg, 0);
        @(posedge clk); #2;
        rstn = 1'b1;

        // write one line, back-to-back beats
        issue(1'b1, 12'd4, 12'd4, "t1");
        run_write("t1", 36, 1'b0, 4);

        // write three lines with random gaps on both sides of the handshake
        issue(1'b1, 12'd0, 12'd2, "t2");
        run_write("t2", 108, 1'b1, 0);

        // read two lines, downstream always ready
        model_total = 72;
        issue(1'b0, 12'd10, 12'd11, "t3");
        run_read("t3", 72, 1'b0);
        check("t3_bound_idx", bus.ctl_bound_index, 11);

        // same read with downstream ready toggling
        issue(1'b0, 12'd10, 12'd11, "t4");
        run_read("t4", 72, 1'b1);

        // bound below start
        issue(1'b1, 12'd5, 12'd3, "t5");
        dones = 0; errs = 0; reloads = 0; beats = 0; done_at = -1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            bus.cmd_valid     = 1'b0;
            bus.s_axis_tvalid = 1'b1;
            #1;
            if (bus.done) begin
                dones++;
                if (done_at < 0) done_at = i;
            end
            if (bus.done && bus.err) errs++;
            if (bus.ctl_addr_reload) reloads++;
            if (bus.s_axis_tvalid && bus.s_axis_tready) beats++;
        end
        bus.s_axis_tvalid = 1'b0;
        check("t5_dones", dones, 1);
        check("t5_errs", errs, 1);
        check("t5_done_within_2", (done_at >= 0 && done_at <= 1), 1);
        check("t5_reloads", reloads, 0);
        check("t5_beats", beats, 0);

        // reset in the middle of a write
        issue(1'b1, 12'd0, 12'd0, "t6");
        beats = 0;
        for (int i = 0; i < 100 && beats < 20; i++) begin
            @(posedge clk); #2;
            bus.cmd_valid     = 1'b0;
            bus.s_axis_tvalid = 1'b1;
            #1;
            if (bus.s_axis_tvalid && bus.s_axis_tready) beats++;
        end
        @(posedge clk); #2;
        rstn = 1'b0;
        @(posedge clk); #3;
        check("t6_rst_cmd_ready", bus.cmd_ready, 1);
        check("t6_rst_busy", bus.busy, 0);
        check("t6_rst_done", bus.done, 0);
        check("t6_rst_s_tready", bus.s_axis_tready, 0);
        check("t6_rst_in_valid", bus.ctl_stream_in_valid, 0);
        check("t6_rst_rw", bus.ctl_rw, 1);
        check("t6_rst_start_idx", bus.ctl_start_index, 0);
        check("t6_rst_state", bus.state_dbg, 0);
        @(posedge clk); #2;
        rstn              = 1'b1;
        bus.s_axis_tvalid = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #3;
            if (bus.done) dones++;
        end
        check("t6_no_done", dones, 0);
        model_total = 36;
        issue(1'b0, 12'd1, 12'd1, "t6n");
        run_read("t6n", 36, 1'b0);

        // final report
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
